// File: rtl/sipo_mem_pkg.sv
// sipo_mem_pkg: shared definitions for the serial-in / parallel-out frame
// collector.
//   state_t      - frame FSM states (FILL, HOLD)
//   DEF_IWIDTH   - default serial word width
//   DEF_NINPUTS  - default number of words per frame
package sipo_mem_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_IWIDTH  = 10;
  localparam int DEF_NINPUTS = 8;

endpackage

// File: rtl/sipo_mem.sv
// sipo_mem: collects NINPUTS serial words into a registered parallel frame,
// then holds the frame until the consumer accepts it.
//
// state | meaning
// ------+-----------------------------------------------------------
// FILL  | collecting words; each en writes out[count], count++
// HOLD  | frame complete (out_valid=1), waiting for out_ready
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   in carries a valid word this cycle
//   in         in   serial word [IWIDTH-1:0]
//   clear      in   synchronous abort: empties frame, clears overrun
//   out_ready  in   consumer accepts the held frame
//   out        out  parallel frame, out[0] is the first word received
//   out_valid  out  complete frame present on out
//   count      out  words captured in the current frame (0..NINPUTS)
//   overrun    out  sticky: a word arrived while the frame was held
module sipo_mem
  import sipo_mem_pkg::*;
#(
  parameter int IWIDTH  = DEF_IWIDTH,
  parameter int NINPUTS = DEF_NINPUTS,
  localparam int CW     = $clog2(NINPUTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IWIDTH-1:0] in,
  input  logic              clear,
  input  logic              out_ready,
  output logic [IWIDTH-1:0] out [NINPUTS-1:0],
  output logic              out_valid,
  output logic [CW-1:0]     count,
  output logic              overrun
);

  state_t        state, state_nxt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] wr_idx;
  logic          wr;
  logic          ovr_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wr        = 1'b0;
    wr_idx    = count;
    ovr_set   = 1'b0;
    if (clear) begin
      state_nxt = FILL;
      count_nxt = '0;
    end else begin
      case (state)
        FILL: begin
          if (en) begin
            wr        = 1'b1;
            count_nxt = count + CW'(1);
            if (count == CW'(NINPUTS - 1)) state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt = FILL;
            // A word arriving on the handoff cycle starts the next frame.
            if (en) begin
              wr        = 1'b1;
              wr_idx    = '0;
              count_nxt = CW'(1);
            end else begin
              count_nxt = '0;
            end
          end else if (en) begin
            ovr_set = 1'b1;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      count   <= count_nxt;
      overrun <= clear ? 1'b0 : (overrun | ovr_set);
    end
  end

  // Writes are only ever issued from FILL (count < NINPUTS) or at handoff
  // (index 0), so no lane beyond NINPUTS-1 is ever addressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NINPUTS; i++) out[i] <= '0;
    end else begin
      for (int i = 0; i < NINPUTS; i++) begin
        if (clear)                           out[i] <= '0;
        else if (wr && (wr_idx == CW'(i)))   out[i] <= in;
      end
    end
  end

  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_sipo_mem.sv
module tb_sipo_mem;
  import sipo_mem_pkg::*;

  localparam int IW = 10;
  localparam int NI = 8;
  localparam int CW = $clog2(NI + 1);

  typedef logic [NI-1:0][IW-1:0] frame_t;
  typedef struct packed {
    frame_t      d;
    logic [31:0] cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [IW-1:0] din = '0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out [NI-1:0];
  logic          out_valid;
  logic [CW-1:0] count;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_seen = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  exp_t exp_q[$];

  sipo_mem #(.IWIDTH(IW), .NINPUTS(NI)) dut (
    .clk(clk), .rst(rst), .en(en), .in(din), .clear(clear),
    .out_ready(out_ready), .out(out), .out_valid(out_valid),
    .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string name, input frame_t f);
    int bad;
    bad = -1;
    for (int i = 0; i < NI; i++) if (out[i] !== f[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: out[%0d] got 0x%0h expected 0x%0h", name, bad, out[bad], f[bad]);
    end
  endtask

  // Monitor: pops an expected frame whenever out_valid rises.
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: out_valid rose with no expected frame at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk_frame("frame_data", e.d);
        chk("frame_count", 32'(count), 32'(NI));
        chk("frame_overrun", 32'(overrun), 32'd0);
        chk("frame_latency_cycle", 32'(cyc), e.cyc);
      end
      last_valid_cyc = cyc;
      frames_seen++;
    end
    prev_valid = out_valid;
  end

  // Called at a negedge; leaves the bench at the negedge after the last word.
  task automatic send_frame(input frame_t f, input int first, input int gap_at, input int gap_len);
    for (int i = first; i < NI; i++) begin
      if (i == NI - 1) exp_q.push_back('{d: f, cyc: 32'(cyc + 1)});
      en  = 1'b1;
      din = f[i];
      @(negedge clk);
      en = 1'b0;
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          #1 chk("gap_count_hold", 32'(count), 32'(gap_at + 1));
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_frame(input int n);
    int t;
    t = 0;
    #1;
    while (frames_seen < n && t < 5) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("frame_seen", 32'(frames_seen >= n), 32'd1);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("handoff_valid", 32'(out_valid), 32'd0);
    chk("handoff_count", 32'(count), 32'd0);
  endtask

  task automatic chk_zero(input string name);
    frame_t z;
    z = '0;
    chk_frame(name, z);
  endtask

  initial begin
    frame_t f_seq, f_ones, f_mix;
    int start;
    for (int i = 0; i < NI; i++) begin
      f_seq[i]  = IW'(i + 1);
      f_ones[i] = 10'h3FF;
      f_mix[i]  = (i == 0) ? 10'h3FF : IW'(32'h10 + i);
    end

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk_zero("reset_out");
    @(negedge clk);

    // Contiguous frame 1..8.
    start = cyc;
    send_frame(f_seq, 0, -1, 0);
    wait_frame(1);
    chk("latency_contiguous", 32'(last_valid_cyc - start), 32'd8);
    handoff();
    @(negedge clk);

    // Same data, 2-cycle gap after word 3, out_ready toggled while filling.
    out_ready = 1'b1;
    start = cyc;
    send_frame(f_seq, 0, 2, 2);
    out_ready = 1'b0;
    wait_frame(2);
    chk("latency_gap", 32'(last_valid_cyc - start), 32'd10);

    // Overrun in HOLD, then clear.
    en  = 1'b1;
    din = 10'h155;
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_valid", 32'(out_valid), 32'd1);
    chk("overrun_count", 32'(count), 32'(NI));
    chk_frame("overrun_out_stable", f_seq);
    @(negedge clk);
    #1 chk("overrun_sticky", 32'(overrun), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clear_overrun", 32'(overrun), 32'd0);
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_valid", 32'(out_valid), 32'd0);
    chk_zero("clear_out");

    // Handoff with a simultaneous word starts the next frame.
    @(negedge clk);
    send_frame(f_seq, 0, -1, 0);
    wait_frame(3);
    out_ready = 1'b1;
    en        = 1'b1;
    din       = 10'h3FF;
    @(negedge clk);
    out_ready = 1'b0;
    en        = 1'b0;
    #1;
    chk("handoff_en_valid", 32'(out_valid), 32'd0);
    chk("handoff_en_count", 32'(count), 32'd1);
    chk("handoff_en_out0", 32'(out[0]), 32'h3FF);
    @(negedge clk);
    send_frame(f_mix, 1, -1, 0);
    wait_frame(4);
    handoff();

    // Asynchronous reset mid-frame.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      en  = 1'b1;
      din = IW'(32'h20 + i);
      @(negedge clk);
    end
    en = 1'b0;
    #1 chk("pre_reset_count", 32'(count), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk_zero("async_reset_out");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    din = 10'h2AA;
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("post_reset_out0", 32'(out[0]), 32'h2AA);
    chk("post_reset_count", 32'(count), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // All-ones frame.
    send_frame(f_ones, 0, -1, 0);
    wait_frame(5);
    chk("ones_valid", 32'(out_valid), 32'd1);
    handoff();

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frames_total", 32'(frames_seen), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
